operand_capture: RTL and testbench

//  Upstream stage of the 7-bit adder/BCD display path. Debounces the four DE2-70 push buttons.

---
 rtl/operand_capture_pkg.sv | 20 ++
 rtl/key_debounce.sv | 55 +++++
 rtl/operand_capture.sv | 112 +++++++++++
 tb/tb_operand_capture.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_capture_pkg.sv
// Shared definitions for the operand capture stage: FSM encoding and push-button roles.
package operand_capture_pkg;

  localparam logic [1:0] EMPTY   = 2'd0;
  localparam logic [1:0] PARTIAL = 2'd1;
  localparam logic [1:0] OFFER   = 2'd2;

  typedef enum logic [1:0] {
    StEmpty   = EMPTY,
    StPartial = PARTIAL,
    StOffer   = OFFER
  } state_e;

  localparam int unsigned NUM_KEYS   = 4;
  localparam int unsigned KEY_LOAD_A = 0;
  localparam int unsigned KEY_LOAD_B = 1;
  localparam int unsigned KEY_COMMIT = 2;
  localparam int unsigned KEY_CLEAR  = 3;

endpackage

// File: rtl/key_debounce.sv
// Synchronizes and debounces one active-low push button.
// Emits a single-cycle pulse when the accepted level falls.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic CLOCK_50,
  input  logic RESET,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntMax) begin
        level_d = sync2_q;
        // Only a released->pressed flip is an event.
        press_d = level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/operand_capture.sv
// Captures operands A/B from the switches on debounced key presses and offers
// the pair downstream over a valid/ready handshake.
module operand_capture
  import operand_capture_pkg::*;
#(
  parameter int unsigned WIDTH           = 7,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic               CLOCK_50,
  input  logic               RESET,
  input  logic [3:0]         KEY,
  input  logic [2*WIDTH-1:0] SW,
  output logic [WIDTH-1:0]   op_a,
  output logic [WIDTH-1:0]   op_b,
  output logic               op_valid,
  input  logic               op_ready,
  output logic               a_loaded,
  output logic               b_loaded
);

  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] unused_key_level;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_key_debounce (
      .CLOCK_50(CLOCK_50),
      .RESET   (RESET),
      .key_n   (KEY[i]),
      .level   (unused_key_level[i]),
      .press   (key_press[i])
    );
  end

  logic load_a, load_b, commit, clear;
  assign load_a = key_press[KEY_LOAD_A];
  assign load_b = key_press[KEY_LOAD_B];
  assign commit = key_press[KEY_COMMIT];
  assign clear  = key_press[KEY_CLEAR];

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             a_loaded_q, a_loaded_d;
  logic             b_loaded_q, b_loaded_d;

  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    a_loaded_d = a_loaded_q;
    b_loaded_d = b_loaded_q;
    if (clear) begin
      // Clear wins even over a same-cycle op_ready; operand values are kept.
      state_d    = StEmpty;
      a_loaded_d = 1'b0;
      b_loaded_d = 1'b0;
    end else begin
      unique case (state_q)
        StOffer: begin
          if (op_ready) begin
            state_d    = StEmpty;
            a_loaded_d = 1'b0;
            b_loaded_d = 1'b0;
          end
        end
        StEmpty, StPartial: begin
          if (load_a) begin
            op_a_d     = SW[WIDTH-1:0];
            a_loaded_d = 1'b1;
          end
          if (load_b) begin
            op_b_d     = SW[2*WIDTH-1:WIDTH];
            b_loaded_d = 1'b1;
          end
          if (load_a || load_b) begin
            state_d = StPartial;
          end else if (commit && (state_q == StPartial) && a_loaded_q && b_loaded_q) begin
            state_d = StOffer;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q    <= StEmpty;
      op_a_q     <= '0;
      op_b_q     <= '0;
      a_loaded_q <= 1'b0;
      b_loaded_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      a_loaded_q <= a_loaded_d;
      b_loaded_q <= b_loaded_d;
    end
  end

  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign op_valid = (state_q == StOffer);
  assign a_loaded = a_loaded_q;
  assign b_loaded = b_loaded_q;

endmodule

// File: tb/tb_operand_capture.sv
// Randomized scoreboard bench for operand_capture with a short debounce window.
module tb_operand_capture;

  localparam int unsigned W  = 7;
  localparam int unsigned DC = 4;
  localparam int unsigned CW = 3;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } pair_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     key;
  logic [2*W-1:0] sw;
  logic [W-1:0]   op_a, op_b;
  logic           op_valid, op_ready, a_loaded, b_loaded;

  always #5 clk = ~clk;

  operand_capture #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (CW)
  ) dut (
    .CLOCK_50(clk),
    .RESET   (rst),
    .KEY     (key),
    .SW      (sw),
    .op_a    (op_a),
    .op_b    (op_b),
    .op_valid(op_valid),
    .op_ready(op_ready),
    .a_loaded(a_loaded),
    .b_loaded(b_loaded)
  );

  int    n_cmp = 0;
  int    n_bad = 0;
  int    n_xfers = 0;
  int    m_xfers = 0;
  pair_t exp_q[$];
  pair_t mon_p;
  bit    clear_coinc = 1'b0;

  // Reference model: what the operand holder should look like after each action.
  logic [W-1:0] m_a = '0, m_b = '0;
  bit           m_ha = 0, m_hb = 0, m_offer = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_check(input string tag);
    check({tag, ".a_loaded"}, a_loaded, m_ha);
    check({tag, ".b_loaded"}, b_loaded, m_hb);
    check({tag, ".op_valid"}, op_valid, m_offer);
    check({tag, ".op_a"}, op_a, m_a);
    check({tag, ".op_b"}, op_b, m_b);
  endtask

  // Hold the masked keys low long enough to debounce, then release cleanly.
  task automatic press(input logic [3:0] mask);
    key = ~mask;
    step(8);
    key = 4'hF;
    step(8);
  endtask

  task automatic model_clear();
    m_ha = 0;
    m_hb = 0;
    if (m_offer) void'(exp_q.pop_back());
    m_offer = 0;
  endtask

  task automatic do_op(input int kind, input logic [2*W-1:0] s);
    sw = s;
    case (kind)
      0: begin
        press(4'b0001);
        if (!m_offer) begin m_a = s[W-1:0]; m_ha = 1; end
      end
      1: begin
        press(4'b0010);
        if (!m_offer) begin m_b = s[2*W-1:W]; m_hb = 1; end
      end
      2: begin
        press(4'b0011);
        if (!m_offer) begin m_a = s[W-1:0]; m_b = s[2*W-1:W]; m_ha = 1; m_hb = 1; end
      end
      3: begin
        press(4'b0100);
        if (!m_offer && m_ha && m_hb) begin
          m_offer = 1;
          exp_q.push_back({m_a, m_b});
        end
      end
      4: begin
        press(4'b0101);
        if (!m_offer) begin m_a = s[W-1:0]; m_ha = 1; end
      end
      5: begin
        press(4'b1000);
        model_clear();
      end
      default: begin
        op_ready = 1'b1;
        step(1);
        op_ready = 1'b0;
        if (m_offer) begin
          m_offer = 0; m_ha = 0; m_hb = 0;
          m_xfers++;
        end
      end
    endcase
    model_check($sformatf("op%0d", kind));
  endtask

  // Monitor: a transfer is valid&ready seen between edges, unless the bench
  // deliberately lined a clear up with it.
  always @(negedge clk) begin
    if (!rst && op_valid && op_ready && !clear_coinc) begin
      n_xfers++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_transfer: got a=%0d b=%0d required none", op_a, op_b);
      end else begin
        mon_p = exp_q.pop_front();
        check("xfer.op_a", op_a, mon_p.a);
        check("xfer.op_b", op_b, mon_p.b);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int  k;
    bit  spurious;
    int  unstable;

    rst = 1'b1; key = 4'hF; sw = 14'h1A5A; op_ready = 1'b0;
    // Reset
    step(3);
    model_check("reset");
    rst = 1'b0;
    spurious = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (a_loaded || b_loaded || op_valid) spurious = 1;
    end
    check("no_press_after_reset", spurious, 0);

    // Bounce on KEY[0], then a clean hold
    sw = {7'd0, 7'd77};
    for (int i = 0; i < 6; i++) begin
      key[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
      step(2);
    end
    key[0] = 1'b0;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (a_loaded) begin k = i; break; end
    end
    check("bounce_latency", k, 7);
    key[0] = 1'b1;
    step(8);
    m_a = 7'd77; m_ha = 1;
    model_check("bounce");

    // Load A=27, B=100, commit, hold offer with changing switches
    do_op(0, {7'd100, 7'd27});
    do_op(1, {7'd100, 7'd27});
    do_op(3, {7'd100, 7'd27});
    unstable = 0;
    for (int i = 0; i < 50; i++) begin
      sw = 14'($urandom);
      step(1);
      if (!op_valid || op_a !== 7'd27 || op_b !== 7'd100) unstable++;
    end
    check("offer_held_cycles_bad", unstable, 0);

    // Single-cycle accept
    do_op(6, sw);
    check("xfer_count_after_accept", n_xfers, 1);

    // Commit with only A loaded is ignored
    do_op(0, {7'd9, 7'd5});
    do_op(3, {7'd9, 7'd5});

    // Clear coincident with op_ready during an offer
    do_op(1, {7'd44, 7'd0});
    do_op(3, 14'h0);
    key = 4'b0111;
    step(6);
    op_ready = 1'b1;
    clear_coinc = 1'b1;
    step(1);
    op_ready = 1'b0;
    clear_coinc = 1'b0;
    key = 4'hF;
    step(8);
    model_clear();
    model_check("clear_vs_ready");
    check("xfer_count_after_clear", n_xfers, m_xfers);

    // Reset while KEY[0] is mid-debounce; the key is released under reset
    sw = 14'h3FFF;
    key = 4'b1110;
    step(3);
    rst = 1'b1;
    step(1);
    key = 4'hF;
    step(1);
    rst = 1'b0;
    step(20);
    model_clear();
    m_a = '0; m_b = '0;
    model_check("reset_mid_debounce");

    // Randomized operation mix
    for (int i = 0; i < 40; i++) begin
      do_op($urandom_range(0, 6), 14'($urandom));
    end
    do_op(2, 14'($urandom));
    do_op(3, 14'($urandom));
    do_op(6, 14'($urandom));

    check("xfer_count_final", n_xfers, m_xfers);
    check("scoreboard_left", exp_q.size(), m_offer ? 1 : 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
